// File: rtl/alu_iterative.sv
// Execution-stage ALU with a valid/ready request/response handshake.
// Logic, arithmetic and compare operations finish in a single cycle.
// Shifts move one bit per cycle through an accumulator rather than a barrel shifter.
module alu_iterative #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SHAMT_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [3:0]            alu_control_i,
    input  logic [DATA_WIDTH-1:0] operand_a_i,
    input  logic [DATA_WIDTH-1:0] operand_b_i,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  acc;
    logic [SHAMT_WIDTH-1:0] cnt;
    logic [3:0]             op_q;

    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   is_shift;
    logic [DATA_WIDTH-1:0]  alu_res;
    logic [DATA_WIDTH-1:0]  acc_next;

    assign shamt       = operand_b_i[SHAMT_WIDTH-1:0];
    assign is_shift    = (alu_control_i == OP_SLL) || (alu_control_i == OP_SRL) ||
                         (alu_control_i == OP_SRA);
    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);

    // Single-cycle result; a shift only takes this path when its amount is zero.
    always_comb begin
        alu_res = operand_a_i + operand_b_i;
        case (alu_control_i)
            OP_SUB:  alu_res = operand_a_i - operand_b_i;
            OP_AND:  alu_res = operand_a_i & operand_b_i;
            OP_OR:   alu_res = operand_a_i | operand_b_i;
            OP_XOR:  alu_res = operand_a_i ^ operand_b_i;
            OP_SLL,
            OP_SRL,
            OP_SRA:  alu_res = operand_a_i;
            OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}},
                                ($signed(operand_a_i) < $signed(operand_b_i))};
            OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (operand_a_i < operand_b_i)};
            default: alu_res = operand_a_i + operand_b_i;
        endcase
    end

    // One-bit step of the captured shift operation.
    always_comb begin
        acc_next = acc;
        case (op_q)
            OP_SLL:  acc_next = {acc[DATA_WIDTH-2:0], 1'b0};
            OP_SRL:  acc_next = {1'b0, acc[DATA_WIDTH-1:1]};
            OP_SRA:  acc_next = {acc[DATA_WIDTH-1], acc[DATA_WIDTH-1:1]};
            default: acc_next = acc;
        endcase
    end

    // Control FSM and result registers; reset beats flush, flush beats both handshakes.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            result_o <= '0;
            zero_o   <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            op_q     <= OP_ADD;
        end else if (flush_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        if (is_shift && (shamt != '0)) begin
                            acc   <= operand_a_i;
                            cnt   <= shamt;
                            op_q  <= alu_control_i;
                            state <= SHIFT;
                        end else begin
                            result_o <= alu_res;
                            zero_o   <= (alu_res == '0);
                            state    <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    acc <= acc_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == SHAMT_WIDTH'(1)) begin
                        result_o <= acc_next;
                        zero_o   <= (acc_next == '0);
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
